// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: default widths and FSM states.
package reg_dump_pkg;

    localparam int unsigned DefaultAw = 5;
    localparam int unsigned DefaultDw = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

endpackage

// File: rtl/reg_dump_if.sv
// Bundle of control, register-file read port and output stream of the dump engine.
interface reg_dump_if
    import reg_dump_pkg::*;
#(
    parameter int unsigned AW = DefaultAw,
    parameter int unsigned DW = DefaultDw
) ();

    logic          start;
    logic          abort;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    // Dump engine side.
    modport master (
        input  start, abort, first, last, rd, out_ready,
        output ra, out_valid, out_data, out_addr, busy, done
    );

    // Controller / register file / consumer side.
    modport slave (
        output start, abort, first, last, rd, out_ready,
        input  ra, out_valid, out_data, out_addr, busy, done
    );

endinterface

// File: rtl/reg_dump.sv
// Walks a register file from first to last (wrapping), streaming each value out
// through a valid/ready register stage.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int unsigned AW = DefaultAw,
    parameter int unsigned DW = DefaultDw
) (
    input logic        clk,
    input logic        rstd,
    reg_dump_if.master bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;

    // State, address counter, end register and output register.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and datapath; abort wins over capture and handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cnt_d   = bus.first;
                    last_d  = bus.last;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (!valid_q || bus.out_ready) begin
                    data_d  = bus.rd;
                    addr_d  = cnt_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + AW'(1);
                    // Capturing the end address finishes the walk; counter wraps mod 2^AW.
                    if (cnt_q == last_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ra        = cnt_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = addr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter AW, default 5, register address width.
REQ-002 Parameter DW, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstd  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  pulse; begins a dump when sampled high in IDLE.
REQ-006 abort  input  1  terminates a dump in progress.
REQ-007 first  input  AW  first register address, sampled on accepted start.
REQ-008 last  input  AW  last register address, sampled on accepted start.
REQ-009 ra  output  AW  read address to register file read port.
REQ-010 rd  input  DW  combinational read data returned for ra in the same cycle.
REQ-011 out_valid  output  1  out_data/out_addr hold a word.
REQ-012 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-013 out_data  output  DW  captured register value.
REQ-014 out_addr  output  AW  address of out_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start high -> latch first into address counter and last into end register, go RUN; start ignored in all other states.
REQ-019 ra SHALL equal the address counter at all times.
REQ-020 RUN: when out_valid is low or out_ready is high, capture rd into out_data and ra into out_addr, set out_valid, and advance the counter (+1 mod 2^AW).
REQ-021 Throughput SHALL be one word per cycle with out_ready held high; first out_valid appears one cycle after start.
REQ-022 The capture of address == last SHALL move RUN -> DRAIN with no further capture.
REQ-023 first > last SHALL wrap 31 -> 0; word count = ((last - first) mod 2^AW) + 1; first == last dumps one word.
REQ-024 out_data/out_addr/out_valid SHALL hold stable while out_valid high and out_ready low.
REQ-025 DRAIN: out_valid && out_ready -> clear out_valid, go DONE.
REQ-026 DONE: assert done for exactly one cycle, go IDLE.
REQ-027 abort high in RUN or DRAIN SHALL clear out_valid and go IDLE next edge, with no done pulse; abort has priority over capture and handshake.
REQ-028 Words SHALL be emitted in ascending address order with no duplicates or gaps.

Reset
REQ-029 rstd high SHALL immediately force IDLE, ra=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, independent of clk.
REQ-030 Reset mid-dump SHALL discard all progress; the first dump after reset release starts cleanly from start.

Structure
REQ-031 Shared package reg_dump_pkg SHALL hold AW/DW defaults and the state enumeration.
REQ-032 No sub-module; counter, end register, output register, and FSM live in reg_dump.

Verification
REQ-033 Bench reg_file model preloaded rf[n]=n*32'h01010101; start first=3 last=6, out_ready=1 -> addrs 3,4,5,6 on four consecutive cycles, data 03030303..06060606, done one cycle after last handshake.
REQ-034 first=30 last=1 -> addrs 30,31,0,1, exactly four words, then done.
REQ-035 first=last=7 -> single word 07070707, done follows.
REQ-036 first=0 last=31, out_ready toggled 1010... -> 32 words in order, out_data stable during every stall, no loss/duplication.
REQ-037 abort asserted at third word of 0..31 dump -> out_valid low next cycle, busy low, done never pulses; new start succeeds.
REQ-038 rstd pulsed between clock edges mid-dump -> outputs zero immediately; start pulsed while busy ignored.
